// File: rtl/demo_pkg.sv
// demo_pkg: shared state encoding and counter width for the advance button channels
package demo_pkg;
   typedef enum logic [2:0] {IDLE, PRESS, HELD, REPEAT, RELEASE} advance_state_t;
   localparam int ADV_CNT_BITS = 6;
endpackage

// File: rtl/advance_chan.sv
// advance_chan: one button channel -- synchronizer, debounce/auto-repeat FSM, registered outputs
module advance_chan
   import demo_pkg::*;
#(
   parameter int DEBOUNCE_FRAMES = 3,
   parameter int REPEAT_DELAY    = 30,
   parameter int REPEAT_PERIOD   = 6
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   input  logic new_frame,
   output logic advance,
   output logic held
);
   localparam logic [ADV_CNT_BITS:0] DF = (ADV_CNT_BITS+1)'(DEBOUNCE_FRAMES);
   localparam logic [ADV_CNT_BITS:0] RD = (ADV_CNT_BITS+1)'(REPEAT_DELAY);
   localparam logic [ADV_CNT_BITS:0] RP = (ADV_CNT_BITS+1)'(REPEAT_PERIOD);
   localparam logic [ADV_CNT_BITS:0] ONE = 1;
   logic [1:0] sync_ff;
   logic sync;
   advance_state_t state, state_nx;
   logic [ADV_CNT_BITS-1:0] cnt, cnt_nx;
   logic [ADV_CNT_BITS:0] cnt_inc;
   logic pulse;
   assign sync = sync_ff[1];
   assign cnt_inc = {1'b0, cnt} + ONE;
   // next state, counter and step pulse; nothing moves except on a frame tick
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      pulse    = 1'b0;
      if (new_frame) begin
         case (state)
            IDLE, PRESS: begin
               if (!sync) begin
                  state_nx = IDLE;
                  cnt_nx   = '0;
               end else if (cnt_inc >= DF) begin
                  state_nx = HELD;
                  cnt_nx   = '0;
                  pulse    = 1'b1;
               end else begin
                  state_nx = PRESS;
                  cnt_nx   = cnt_inc[ADV_CNT_BITS-1:0];
               end
            end
            HELD, REPEAT: begin
               if (!sync) begin
                  state_nx = RELEASE;
                  cnt_nx   = 1;
               end else if (cnt_inc >= ((state == HELD) ? RD : RP)) begin
                  state_nx = REPEAT;
                  cnt_nx   = '0;
                  pulse    = 1'b1;
               end else begin
                  cnt_nx   = cnt_inc[ADV_CNT_BITS-1:0];
               end
            end
            RELEASE: begin
               if (sync) begin
                  cnt_nx   = '0;
               end else if (cnt_inc >= DF) begin
                  state_nx = IDLE;
                  cnt_nx   = '0;
               end else begin
                  cnt_nx   = cnt_inc[ADV_CNT_BITS-1:0];
               end
            end
            default: begin
               state_nx = IDLE;
               cnt_nx   = '0;
            end
         endcase
      end
   end
   // synchronizer, state register and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_ff <= '0;
         state   <= IDLE;
         cnt     <= '0;
         advance <= 1'b0;
         held    <= 1'b0;
      end else begin
         sync_ff <= {sync_ff[0], btn};
         state   <= state_nx;
         cnt     <= cnt_nx;
         advance <= pulse;
         held    <= (state_nx == HELD) || (state_nx == REPEAT);
      end
   end
endmodule

// File: rtl/advance_ctrl.sv
// advance_ctrl: two independent debounced, auto-repeating step buttons for the demo core
module advance_ctrl
   import demo_pkg::*;
#(
   parameter int DEBOUNCE_FRAMES = 3,
   parameter int REPEAT_DELAY    = 30,
   parameter int REPEAT_PERIOD   = 6
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] btn,
   input  logic       new_frame,
   output logic [1:0] advance,
   output logic [1:0] held
);
   for (genvar i = 0; i < 2; i++) begin : g_chan
      advance_chan #(
         .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES),
         .REPEAT_DELAY   (REPEAT_DELAY),
         .REPEAT_PERIOD  (REPEAT_PERIOD)
      ) u_chan (
         .clk      (clk),
         .rst_n    (rst_n),
         .btn      (btn[i]),
         .new_frame(new_frame),
         .advance  (advance[i]),
         .held     (held[i])
      );
   end
endmodule
